sprite_frame_scheduler: RTL and testbench

Parametrised frame renderer and hit tracker for the VGA game. On each frame tick it clears the screen in raster order, then draws every live sprite as a solid SPR_W x SPR_H rectangle. Its single-pixel plot stream drives the vga_adapter x/y/colour/plot inputs directly. In parallel it keeps a registered alive mask, kills the lowest-indexed sprite hit by the beam, and counts hits.

---
 rtl/sprite_frame_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_sprite_frame_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_frame_scheduler.sv
// -----------------------------------------------------------------------------
// sprite_frame_scheduler
//
// Frame renderer and hit tracker for the VGA game. On a frame tick the block
// clears the screen one pixel per cycle in raster order. It then visits every
// sprite in index order and draws each live one as a solid SPR_W x SPR_H
// rectangle. The single-pixel plot stream feeds the vga_adapter x/y/colour/plot
// inputs directly. Pixels that fall off the screen still take a cycle, but they
// are not plotted.
//
// Independently of rendering, a beam point is checked against every live sprite
// on every cycle. The lowest-indexed sprite that is hit is killed, and a
// saturating kill counter is stepped.
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   frame_tick                   one-cycle frame start request
//   spr_x / spr_y / spr_colour   packed per-sprite position and colour
//   beam_valid, beam_x, beam_y   beam point for collision checks
//   revive                       sets every alive bit on the next edge
//   x, y, colour, plot           registered pixel stream for the vga_adapter
//   busy                         frame in progress
//   alive                        registered alive mask
//   beam_hit, hit_index          kill pulse and index of the last kill
//   hit_count                    saturating kill count
//   all_dead                     combinational alive == 0
//   overrun                      sticky: frame_tick arrived while busy
// -----------------------------------------------------------------------------
module sprite_frame_scheduler #(
   parameter int N     = 8,
   parameter int SPR_W = 4,
   parameter int SPR_H = 4,
   parameter int SCR_W = 160,
   parameter int SCR_H = 120,
   parameter int XW    = 8,
   parameter int YW    = 7
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic                              frame_tick,
   input  logic [N*XW-1:0]                   spr_x,
   input  logic [N*YW-1:0]                   spr_y,
   input  logic [N*3-1:0]                    spr_colour,
   input  logic                              beam_valid,
   input  logic [XW-1:0]                     beam_x,
   input  logic [YW-1:0]                     beam_y,
   input  logic                              revive,
   output logic [XW-1:0]                     x,
   output logic [YW-1:0]                     y,
   output logic [2:0]                        colour,
   output logic                              plot,
   output logic                              busy,
   output logic [N-1:0]                      alive,
   output logic                              beam_hit,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] hit_index,
   output logic [7:0]                        hit_count,
   output logic                              all_dead,
   output logic                              overrun
);

   localparam int IW  = (N > 1) ? $clog2(N) : 1;
   localparam int DXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int DYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_SCAN  = 2'd2,
      ST_DRAW  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [XW-1:0]   cx_q, cx_d;
   logic [YW-1:0]   cy_q, cy_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [DXW-1:0]  dx_q, dx_d;
   logic [DYW-1:0]  dy_q, dy_d;
   logic [XW-1:0]   sx_q, sx_d;
   logic [YW-1:0]   sy_q, sy_d;
   logic [2:0]      scol_q, scol_d;

   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [2:0]      colour_q, colour_d;
   logic            plot_q, plot_d;
   logic            busy_q, busy_d;
   logic            overrun_q, overrun_d;

   logic [N-1:0]    alive_q, alive_d;
   logic            beam_hit_q, beam_hit_d;
   logic [IW-1:0]   hit_index_q, hit_index_d;
   logic [7:0]      hit_count_q, hit_count_d;

   // Pixel request from the FSM: base corner, offset and colour of the next pixel.
   logic            draw_req_s;
   logic [XW-1:0]   dbx_s;
   logic [YW-1:0]   dby_s;
   logic [DXW-1:0]  ddx_s;
   logic [DYW-1:0]  ddy_s;
   logic [2:0]      dcol_s;
   logic [XW:0]     sum_x_s;
   logic [YW:0]     sum_y_s;

   logic [N-1:0]    hit_vec_s;
   logic            hit_any_s;
   logic [IW-1:0]   hit_idx_s;

   // Beam inside a sprite box; one extra bit keeps sx+SPR_W-1 from wrapping.
   function automatic logic in_box(input logic [XW-1:0] sx, input logic [YW-1:0] sy,
                                   input logic [XW-1:0] bx, input logic [YW-1:0] by);
      logic [XW:0] bxw, sxw;
      logic [YW:0] byw, syw;
      bxw = {1'b0, bx};
      sxw = {1'b0, sx};
      byw = {1'b0, by};
      syw = {1'b0, sy};
      in_box = (bxw >= sxw) && (bxw <= sxw + (XW+1)'(SPR_W - 1)) &&
               (byw >= syw) && (byw <= syw + (YW+1)'(SPR_H - 1));
   endfunction

   // Render FSM next state, counters and next pixel on the plot outputs.
   always_comb begin
      state_d    = state_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      idx_d      = idx_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      sx_d       = sx_q;
      sy_d       = sy_q;
      scol_d     = scol_q;
      x_d        = x_q;
      y_d        = y_q;
      colour_d   = colour_q;
      plot_d     = 1'b0;
      draw_req_s = 1'b0;
      dbx_s      = sx_q;
      dby_s      = sy_q;
      ddx_s      = dx_q;
      ddy_s      = dy_q;
      dcol_s     = scol_q;

      case (state_q)
         ST_IDLE: begin
            if (frame_tick) begin
               state_d  = ST_CLEAR;
               cx_d     = '0;
               cy_d     = '0;
               x_d      = '0;
               y_d      = '0;
               colour_d = 3'd0;
               plot_d   = 1'b1;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if ((cx_q == XW'(SCR_W - 1)) && (cy_q == YW'(SCR_H - 1))) begin
               state_d = ST_SCAN;
               idx_d   = '0;
            end else begin
               if (cx_q == XW'(SCR_W - 1)) begin
                  cx_d = '0;
                  cy_d = cy_q + YW'(1);
               end else begin
                  cx_d = cx_q + XW'(1);
               end
               x_d      = cx_d;
               y_d      = cy_d;
               colour_d = 3'd0;
               plot_d   = 1'b1;
            end
         end
         ST_SCAN: begin
            if (alive_q[idx_q]) begin
               // Latch the sprite once so input changes cannot tear it mid-draw.
               state_d    = ST_DRAW;
               sx_d       = spr_x[int'(idx_q)*XW +: XW];
               sy_d       = spr_y[int'(idx_q)*YW +: YW];
               scol_d     = spr_colour[int'(idx_q)*3 +: 3];
               dx_d       = '0;
               dy_d       = '0;
               draw_req_s = 1'b1;
               dbx_s      = sx_d;
               dby_s      = sy_d;
               ddx_s      = '0;
               ddy_s      = '0;
               dcol_s     = scol_d;
            end else if (idx_q == IW'(N - 1)) begin
               state_d = ST_IDLE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         ST_DRAW: begin
            if ((dx_q == DXW'(SPR_W - 1)) && (dy_q == DYW'(SPR_H - 1))) begin
               if (idx_q == IW'(N - 1)) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_SCAN;
                  idx_d   = idx_q + IW'(1);
               end
            end else begin
               if (dx_q == DXW'(SPR_W - 1)) begin
                  dx_d = '0;
                  dy_d = dy_q + DYW'(1);
               end else begin
                  dx_d = dx_q + DXW'(1);
               end
               draw_req_s = 1'b1;
               ddx_s      = dx_d;
               ddy_s      = dy_d;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Sprite pixel: widened sums so off-screen pixels are detected, not wrapped.
      sum_x_s = {1'b0, dbx_s} + (XW+1)'(ddx_s);
      sum_y_s = {1'b0, dby_s} + (YW+1)'(ddy_s);
      if (draw_req_s) begin
         x_d      = sum_x_s[XW-1:0];
         y_d      = sum_y_s[YW-1:0];
         colour_d = dcol_s;
         plot_d   = (sum_x_s < (XW+1)'(SCR_W)) && (sum_y_s < (YW+1)'(SCR_H));
      end else begin
         colour_d = colour_d;
      end

      busy_d    = (state_d != ST_IDLE);
      overrun_d = overrun_q | (frame_tick && (state_q != ST_IDLE));
   end

   // Collision detect: lowest-indexed live sprite under the beam wins.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         hit_vec_s[i] = beam_valid && alive_q[i] &&
                        in_box(spr_x[i*XW +: XW], spr_y[i*YW +: YW], beam_x, beam_y);
      end
      hit_any_s = |hit_vec_s;
      hit_idx_s = '0;
      for (int i = N - 1; i >= 0; i--) begin
         hit_idx_s = hit_vec_s[i] ? IW'(i) : hit_idx_s;
      end
   end

   // Alive mask and hit bookkeeping; revive overrides a simultaneous kill.
   always_comb begin
      alive_d     = alive_q;
      beam_hit_d  = 1'b0;
      hit_index_d = hit_index_q;
      hit_count_d = hit_count_q;
      if (revive) begin
         alive_d = '1;
      end else if (hit_any_s) begin
         alive_d[hit_idx_s] = 1'b0;
         beam_hit_d         = 1'b1;
         hit_index_d        = hit_idx_s;
         hit_count_d        = (hit_count_q == 8'd255) ? hit_count_q : hit_count_q + 8'd1;
      end else begin
         beam_hit_d = 1'b0;
      end
   end

   // Render FSM state and working counters.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cx_q    <= '0;
         cy_q    <= '0;
         idx_q   <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         scol_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         idx_q   <= idx_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         scol_q  <= scol_d;
      end
   end

   // Registered pixel stream, busy and sticky overrun flag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x_q       <= '0;
         y_q       <= '0;
         colour_q  <= 3'd0;
         plot_q    <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         colour_q  <= colour_d;
         plot_q    <= plot_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   // Alive mask, kill pulse, last kill index and kill counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         alive_q     <= '1;
         beam_hit_q  <= 1'b0;
         hit_index_q <= '0;
         hit_count_q <= 8'd0;
      end else begin
         alive_q     <= alive_d;
         beam_hit_q  <= beam_hit_d;
         hit_index_q <= hit_index_d;
         hit_count_q <= hit_count_d;
      end
   end

   assign x         = x_q;
   assign y         = y_q;
   assign colour    = colour_q;
   assign plot      = plot_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;
   assign alive     = alive_q;
   assign beam_hit  = beam_hit_q;
   assign hit_index = hit_index_q;
   assign hit_count = hit_count_q;
   assign all_dead  = (alive_q == '0);

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Scoreboard bench for sprite_frame_scheduler on a small 16x8 screen with
// 4 sprites of 3x2. Stimulus tasks push expected pixels and collision results
// into queues; a monitor pops and compares them whenever the DUT presents output.
module tb_sprite_frame_scheduler;

   localparam int N = 4, SPR_W = 3, SPR_H = 2, SCR_W = 16, SCR_H = 8;
   localparam int XW = 5, YW = 4, IW = 2;

   logic clk = 1'b0;
   logic resetn, frame_tick, beam_valid, revive;
   logic [N*XW-1:0] spr_x;
   logic [N*YW-1:0] spr_y;
   logic [N*3-1:0]  spr_colour;
   logic [XW-1:0]   beam_x, x;
   logic [YW-1:0]   beam_y, y;
   logic [2:0]      colour;
   logic            plot, busy, beam_hit, all_dead, overrun;
   logic [N-1:0]    alive;
   logic [IW-1:0]   hit_index;
   logic [7:0]      hit_count;

   sprite_frame_scheduler #(.N(N), .SPR_W(SPR_W), .SPR_H(SPR_H), .SCR_W(SCR_W),
                            .SCR_H(SCR_H), .XW(XW), .YW(YW)) dut (
      .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
      .spr_x(spr_x), .spr_y(spr_y), .spr_colour(spr_colour),
      .beam_valid(beam_valid), .beam_x(beam_x), .beam_y(beam_y), .revive(revive),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .alive(alive),
      .beam_hit(beam_hit), .hit_index(hit_index), .hit_count(hit_count),
      .all_dead(all_dead), .overrun(overrun));

   always #5 clk = ~clk;

   typedef struct packed { logic [XW-1:0] x; logic [YW-1:0] y; logic [2:0] c; } pix_t;
   typedef struct packed { logic [N-1:0] alive; logic hit; logic [IW-1:0] idx; logic [7:0] cnt; } col_t;

   pix_t pix_q[$];
   col_t col_q[$];

   int total = 0;
   int bad   = 0;

   // Reference state: sprite table, alive flags, kill count, last kill index.
   int mx[N], my[N], mc[N];
   bit m_alive[N];
   int m_cnt = 0;
   int m_idx = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] alive_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_alive[i];
      return v;
   endfunction

   task automatic set_sprites();
      for (int i = 0; i < N; i++) begin
         spr_x[i*XW +: XW] = XW'(mx[i]);
         spr_y[i*YW +: YW] = YW'(my[i]);
         spr_colour[i*3 +: 3] = 3'(mc[i]);
      end
   endtask

   // Monitor: compare plotted pixels and collision results against the queues.
   always @(posedge clk) begin : monitor
      pix_t p;
      col_t c;
      #1;
      if (resetn) begin
         if (plot) begin
            if (pix_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_plot: got plot at (%0d,%0d) expected none", x, y);
            end else begin
               p = pix_q.pop_front();
               check("plot_x", int'(x), int'(p.x));
               check("plot_y", int'(y), int'(p.y));
               check("plot_colour", int'(colour), int'(p.c));
            end
         end
         if (col_q.size() > 0) begin
            c = col_q.pop_front();
            check("alive", int'(alive), int'(c.alive));
            check("beam_hit", int'(beam_hit), int'(c.hit));
            check("hit_index", int'(hit_index), int'(c.idx));
            check("hit_count", int'(hit_count), int'(c.cnt));
            check("all_dead", int'(all_dead), int'(c.alive == '0));
         end
      end
   end

   // One collision cycle; call just after a falling edge.
   task automatic col_step(input bit valid, input int bx, input int by, input bit rv);
      col_t e;
      int hit;
      beam_valid = valid;
      beam_x     = XW'(bx);
      beam_y     = YW'(by);
      revive     = rv;
      hit = -1;
      for (int i = N - 1; i >= 0; i--) begin
         if (valid && m_alive[i] && bx >= mx[i] && bx <= mx[i] + SPR_W - 1 &&
             by >= my[i] && by <= my[i] + SPR_H - 1) hit = i;
      end
      e.hit = 1'b0;
      if (rv) begin
         for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
      end else if (hit >= 0) begin
         m_alive[hit] = 1'b0;
         m_idx = hit;
         m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
         e.hit = 1'b1;
      end
      e.alive = alive_vec();
      e.idx   = IW'(m_idx);
      e.cnt   = 8'(m_cnt);
      col_q.push_back(e);
   endtask

   // Push the whole expected pixel stream of one frame; return its cycle count.
   task automatic build_frame(output int exp_len);
      pix_t p;
      exp_len = SCR_W * SCR_H + N;
      for (int cy = 0; cy < SCR_H; cy++)
         for (int cx = 0; cx < SCR_W; cx++) begin
            p.x = XW'(cx); p.y = YW'(cy); p.c = 3'd0;
            pix_q.push_back(p);
         end
      for (int i = 0; i < N; i++) begin
         if (m_alive[i]) begin
            exp_len += SPR_W * SPR_H;
            for (int dy = 0; dy < SPR_H; dy++)
               for (int dx = 0; dx < SPR_W; dx++)
                  if (mx[i] + dx < SCR_W && my[i] + dy < SCR_H) begin
                     p.x = XW'(mx[i] + dx); p.y = YW'(my[i] + dy); p.c = 3'(mc[i]);
                     pix_q.push_back(p);
                  end
         end
      end
   endtask

   task automatic run_frame(input bit ovr);
      int exp_len, len;
      build_frame(exp_len);
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      check("busy_start", int'(busy), 1);
      len = 0;
      while (busy && len < 2000) begin
         frame_tick = (ovr && len == 5);
         len++;
         @(posedge clk);
         #1;
      end
      frame_tick = 1'b0;
      check("frame_len", len, exp_len);
      check("idle_plot", int'(plot), 0);
      check("pix_queue_empty", pix_q.size(), 0);
      check("overrun", int'(overrun), int'(ovr));
   endtask

   task automatic rand_sprites(input int xmax, input int ymax);
      for (int i = 0; i < N; i++) begin
         mx[i] = $urandom_range(xmax, 0);
         my[i] = $urandom_range(ymax, 0);
         mc[i] = $urandom_range(7, 0);
      end
      set_sprites();
   endtask

   initial begin
      int j, bx, by;
      resetn = 1'b0; frame_tick = 1'b0; beam_valid = 1'b0; revive = 1'b0;
      beam_x = '0; beam_y = '0; spr_x = '0; spr_y = '0; spr_colour = '0;
      for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
      #17;
      check("rst_x", int'(x), 0);
      check("rst_y", int'(y), 0);
      check("rst_colour", int'(colour), 0);
      check("rst_plot", int'(plot), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_alive", int'(alive), 15);
      check("rst_beam_hit", int'(beam_hit), 0);
      check("rst_hit_index", int'(hit_index), 0);
      check("rst_hit_count", int'(hit_count), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_all_dead", int'(all_dead), 0);
      @(negedge clk);
      resetn = 1'b1;

      // Directed frame: corner clipping, normal sprites, fully off-screen sprite.
      mx = '{15, 1, 5, 30}; my = '{7, 1, 2, 15}; mc = '{1, 2, 3, 4};
      set_sprites();
      run_frame(1'b0);

      // Overlapping sprites 0 and 1: sprite 0 dies first, then sprite 1.
      mx = '{4, 4, 20, 20}; my = '{4, 4, 10, 10}; mc = '{5, 6, 7, 1};
      set_sprites();
      @(negedge clk); col_step(1'b1, 5, 5, 1'b0);
      @(negedge clk); col_step(1'b1, 5, 5, 1'b0);
      @(negedge clk); col_step(1'b0, 0, 0, 1'b0);
      @(negedge clk); col_step(1'b0, 0, 0, 1'b0);
      // Dead sprites 0 and 1 are skipped by the next frame.
      run_frame(1'b0);
      // Revive coinciding with a hit on sprite 2.
      @(negedge clk); col_step(1'b1, 20, 10, 1'b1);
      @(negedge clk); col_step(1'b0, 0, 0, 1'b0);

      // Randomized collision rounds interleaved with frames.
      for (int r = 0; r < 24; r++) begin
         rand_sprites(8, 6);
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            j = $urandom_range(N - 1, 0);
            if ($urandom_range(3, 0) == 0) begin
               bx = $urandom_range(31, 0); by = $urandom_range(15, 0);
            end else begin
               bx = mx[j] + $urandom_range(SPR_W, 0); by = my[j] + $urandom_range(SPR_H, 0);
            end
            col_step($urandom_range(7, 0) != 0, bx, by, $urandom_range(9, 0) == 0);
         end
         @(negedge clk); col_step(1'b0, 0, 0, 1'b0);
         if (r % 6 == 5) begin
            rand_sprites(20, 10);
            run_frame(1'b0);
         end
      end

      // Saturation: all sprites stacked, frequent kills with revives between.
      mx = '{2, 2, 2, 2}; my = '{2, 2, 2, 2};
      set_sprites();
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         col_step(1'b1, 2 + $urandom_range(SPR_W - 1, 0), 2 + $urandom_range(SPR_H - 1, 0),
                  $urandom_range(4, 0) == 0);
      end
      @(negedge clk); col_step(1'b0, 0, 0, 1'b0);
      @(negedge clk); col_step(1'b0, 0, 0, 1'b1);
      @(posedge clk); #2;
      check("hit_count_saturated", int'(hit_count), 255);

      // Overrun: extra tick during the clear phase leaves the frame unchanged.
      rand_sprites(20, 10);
      run_frame(1'b1);

      // Reset in the middle of drawing sprite 0.
      mx[0] = 2; my[0] = 2;
      set_sprites();
      begin
         int exp_len;
         build_frame(exp_len);
      end
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      repeat (SCR_W * SCR_H + 1) @(posedge clk);
      #3;
      check("pre_reset_plot", int'(plot), 1);
      resetn = 1'b0;
      #1;
      check("mid_reset_plot", int'(plot), 0);
      check("mid_reset_busy", int'(busy), 0);
      check("mid_reset_alive", int'(alive), 15);
      check("mid_reset_overrun", int'(overrun), 0);
      check("mid_reset_hit_count", int'(hit_count), 0);
      pix_q.delete();
      for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
      m_cnt = 0; m_idx = 0;
      @(negedge clk);
      resetn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check("post_reset_plot", int'(plot), 0);
         check("post_reset_busy", int'(busy), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
